jive_srec_loader: RTL and testbench

- Byte-stream consumer placed directly downstream of the UART receiver. Parses Motorola S-record text (S0–S9) and turns each data byte into a byte-lane write on a 32-bit memory port. This is the boot path that loads the program image into RAM over the serial link.
- Reports the entry address from the termination record and keeps sticky checksum and format error flags for the boot firmware.

---
 rtl/jive_srec_pkg.sv | 33 +++
 rtl/jive_srec_loader_if.sv | 24 ++
 rtl/jive_hex_nibble.sv | 24 ++
 rtl/jive_srec_loader.sv | 179 +++++++++++++++++
 tb/tb_jive_srec_loader.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jive_srec_pkg.sv
// Shared types and constants for the S-record boot loader.
// Also holds the per-record-type address-length lookup.
package jive_srec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        TYPE,
        COUNT,
        ADDR,
        DATA,
        CSUM
    } state_t;

    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_4  = 8'h34;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_UF = 8'h46;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h66;

    // Address field length in bytes for each accepted record type digit.
    function automatic logic [2:0] addr_len_of(input logic [3:0] rec_type);
        case (rec_type)
            4'd2, 4'd8: return 3'd3;
            4'd3, 4'd7: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/jive_srec_loader_if.sv
// Byte-stream input and byte-lane memory write port of the S-record loader.
// The loader side is the master; the UART/memory environment is the slave.
interface jive_srec_loader_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_bena;
    logic              mem_wren;
    logic              mem_ack;

    modport master (
        input  in_data, in_valid, mem_ack,
        output in_ready, mem_addr, mem_wdata, mem_bena, mem_wren
    );

    modport slave (
        output in_data, in_valid, mem_ack,
        input  in_ready, mem_addr, mem_wdata, mem_bena, mem_wren
    );
endinterface

// File: rtl/jive_hex_nibble.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module jive_hex_nibble
    import jive_srec_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [3:0] value,
    output logic       is_hex
);

    // Letters land on 1..6 in the low nibble, so +9 maps them to 10..15.
    always_comb begin
        value  = 4'd0;
        is_hex = 1'b0;
        if (ascii >= ASCII_0 && ascii <= ASCII_9) begin
            value  = ascii[3:0];
            is_hex = 1'b1;
        end else if ((ascii >= ASCII_UA && ascii <= ASCII_UF) ||
                     (ascii >= ASCII_LA && ascii <= ASCII_LF)) begin
            value  = ascii[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/jive_srec_loader.sv
// Motorola S-record parser that turns data bytes into byte-lane RAM writes.
// Reports the entry address of the termination record plus sticky status.
module jive_srec_loader
    import jive_srec_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    jive_srec_loader_if.master  bus,
    output logic                done,
    output logic [31:0]         entry,
    output logic                err_csum,
    output logic                err_fmt,
    output logic [15:0]         rec_cnt
);

    state_t            state;
    logic [3:0]        rec_type;
    logic [2:0]        addr_len;
    logic [1:0]        addr_idx;
    logic              lo_nibble;
    logic [3:0]        hi_nib;
    logic [7:0]        sum;
    logic [7:0]        data_left;
    logic [31:0]       addr_q;
    logic [ADDR_W-1:0] waddr;

    logic [3:0]        nib_val;
    logic              nib_ok;
    logic              take;
    logic [7:0]        byte_val;
    logic [7:0]        sum_next;
    logic [31:0]       addr_shift;
    logic              is_write_type;
    logic              is_term_type;
    logic              type_ok;

    jive_hex_nibble u_hex (
        .ascii  (bus.in_data),
        .value  (nib_val),
        .is_hex (nib_ok)
    );

    assign bus.in_ready  = (state != IDLE) && !bus.mem_wren;
    assign take          = bus.in_valid && bus.in_ready;
    assign byte_val      = {hi_nib, nib_val};
    assign sum_next      = sum + byte_val;
    assign addr_shift    = {addr_q[23:0], byte_val};
    assign is_write_type = (rec_type >= 4'd1) && (rec_type <= 4'd3);
    assign is_term_type  = (rec_type >= 4'd7) && (rec_type <= 4'd9);
    assign type_ok       = (bus.in_data >= ASCII_0) && (bus.in_data <= ASCII_9) &&
                           (bus.in_data != ASCII_4);

    // Single parser FSM; a pending write blocks input, so the ack path and
    // the byte path never update waddr in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rec_type      <= 4'd0;
            addr_len      <= 3'd2;
            addr_idx      <= 2'd0;
            lo_nibble     <= 1'b0;
            hi_nib        <= 4'd0;
            sum           <= 8'd0;
            data_left     <= 8'd0;
            addr_q        <= 32'd0;
            waddr         <= '0;
            bus.mem_wren  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            bus.mem_bena  <= 4'd0;
            done          <= 1'b0;
            entry         <= 32'd0;
            err_csum      <= 1'b0;
            err_fmt       <= 1'b0;
            rec_cnt       <= 16'd0;
        end else if (start) begin
            state        <= HUNT;
            lo_nibble    <= 1'b0;
            bus.mem_wren <= 1'b0;
            done         <= 1'b0;
            entry        <= 32'd0;
            err_csum     <= 1'b0;
            err_fmt      <= 1'b0;
            rec_cnt      <= 16'd0;
        end else begin
            if (bus.mem_wren && bus.mem_ack) begin
                bus.mem_wren <= 1'b0;
                waddr        <= waddr + ADDR_W'(1);
            end

            if (take) begin
                case (state)
                    HUNT: begin
                        if (bus.in_data == ASCII_S)
                            state <= TYPE;
                    end
                    TYPE: begin
                        if (type_ok) begin
                            rec_type  <= bus.in_data[3:0];
                            addr_len  <= addr_len_of(bus.in_data[3:0]);
                            lo_nibble <= 1'b0;
                            state     <= COUNT;
                        end else begin
                            err_fmt <= 1'b1;
                            state   <= HUNT;
                        end
                    end
                    COUNT, ADDR, DATA, CSUM: begin
                        if (!nib_ok) begin
                            err_fmt   <= 1'b1;
                            lo_nibble <= 1'b0;
                            state     <= HUNT;
                        end else if (!lo_nibble) begin
                            hi_nib    <= nib_val;
                            lo_nibble <= 1'b1;
                        end else begin
                            lo_nibble <= 1'b0;
                            case (state)
                                COUNT: begin
                                    if (byte_val < ({5'd0, addr_len} + 8'd1)) begin
                                        err_fmt <= 1'b1;
                                        state   <= HUNT;
                                    end else begin
                                        data_left <= byte_val - {5'd0, addr_len} - 8'd1;
                                        sum       <= byte_val;
                                        addr_q    <= 32'd0;
                                        addr_idx  <= 2'd0;
                                        state     <= ADDR;
                                    end
                                end
                                ADDR: begin
                                    sum      <= sum_next;
                                    addr_q   <= addr_shift;
                                    addr_idx <= addr_idx + 2'd1;
                                    if ({1'b0, addr_idx} == addr_len - 3'd1) begin
                                        waddr <= ADDR_W'(addr_shift);
                                        state <= (data_left == 8'd0) ? CSUM : DATA;
                                    end
                                end
                                DATA: begin
                                    sum       <= sum_next;
                                    data_left <= data_left - 8'd1;
                                    if (is_write_type) begin
                                        bus.mem_wren  <= 1'b1;
                                        bus.mem_addr  <= waddr;
                                        bus.mem_bena  <= 4'b0001 << waddr[1:0];
                                        bus.mem_wdata <= {4{byte_val}};
                                    end
                                    if (data_left == 8'd1)
                                        state <= CSUM;
                                end
                                default: begin
                                    if (sum_next == 8'hFF) begin
                                        rec_cnt <= rec_cnt + 16'd1;
                                        if (is_term_type) begin
                                            entry <= addr_q;
                                            done  <= 1'b1;
                                            state <= IDLE;
                                        end else begin
                                            state <= HUNT;
                                        end
                                    end else begin
                                        err_csum <= 1'b1;
                                        state    <= HUNT;
                                    end
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jive_srec_loader.sv
// Self-checking bench for jive_srec_loader: directed records from the test plan
// plus randomized records scored against a record-level reference model.
module tb_jive_srec_loader;

    localparam int ADDR_W = 32;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  bena;
        logic [31:0] wdata;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [31:0] entry;
    logic        err_csum;
    logic        err_fmt;
    logic [15:0] rec_cnt;

    jive_srec_loader_if #(.ADDR_W(ADDR_W)) bus ();

    jive_srec_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .done     (done),
        .entry    (entry),
        .err_csum (err_csum),
        .err_fmt  (err_fmt),
        .rec_cnt  (rec_cnt)
    );

    always #5 clk = ~clk;

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  ack_delay    = 0;
    bit  stall_chk    = 1'b0;
    bit  stray_ack    = 1'b0;
    bit  lower_hex    = 1'b0;
    bit  gaps         = 1'b0;

    wr_t got_wr[$];
    wr_t exp_wr[$];

    bit          m_done;
    bit          m_csum;
    bit          m_fmt;
    logic [31:0] m_entry;
    logic [15:0] m_rec;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: logs each request once, acks after ack_delay cycles.
    initial begin : responder
        bit  seen;
        int  wait_cnt;
        wr_t cur;
        seen        = 1'b0;
        wait_cnt    = 0;
        cur         = '0;
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (rst) begin
                seen = 1'b0;
            end else if (bus.mem_wren) begin
                if (!seen) begin
                    cur = '{bus.mem_addr, bus.mem_bena, bus.mem_wdata};
                    got_wr.push_back(cur);
                    seen     = 1'b1;
                    wait_cnt = ack_delay;
                end else if (stall_chk) begin
                    checkOutput("stall_in_ready", bus.in_ready, 0);
                    checkOutput("stall_addr", bus.mem_addr, cur.addr);
                    checkOutput("stall_wdata", bus.mem_wdata, cur.wdata);
                end
                if (wait_cnt == 0) begin
                    bus.mem_ack = 1'b1;
                    seen        = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else begin
                seen = 1'b0;
                if (stray_ack && $urandom_range(0, 3) == 0)
                    bus.mem_ack = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int alen_of(input int t);
        if (t == 2 || t == 8) return 3;
        if (t == 3 || t == 7) return 4;
        return 2;
    endfunction

    function automatic string hex2(input logic [7:0] v);
        return lower_hex ? $sformatf("%02x", v) : $sformatf("%02X", v);
    endfunction

    function automatic string make_record(input int t, input logic [31:0] addr,
                                          input byte_q_t data, input bit bad);
        int          al;
        logic [7:0]  cnt;
        logic [7:0]  sum;
        logic [7:0]  b;
        string       s;
        al  = alen_of(t);
        cnt = 8'(al + data.size() + 1);
        s   = {$sformatf("S%0d", t), hex2(cnt)};
        sum = cnt;
        for (int i = al - 1; i >= 0; i--) begin
            b   = addr[i*8 +: 8];
            sum = sum + b;
            s   = {s, hex2(b)};
        end
        foreach (data[i]) begin
            sum = sum + data[i];
            s   = {s, hex2(data[i])};
        end
        b = ~sum;
        if (bad) b = b ^ 8'h01;
        return {s, hex2(b)};
    endfunction

    // Reference model: what a whole record must do to memory and status.
    task automatic model_record(input int t, input logic [31:0] addr,
                                input byte_q_t data, input bit bad);
        logic [31:0] a;
        if (t >= 1 && t <= 3) begin
            foreach (data[i]) begin
                a = addr + 32'(i);
                exp_wr.push_back('{a, 4'b0001 << a[1:0], {4{data[i]}}});
            end
        end
        if (bad) begin
            m_csum = 1'b1;
        end else begin
            m_rec = m_rec + 16'd1;
            if (t >= 7) begin
                m_done  = 1'b1;
                m_entry = addr;
            end
        end
    endtask

    task automatic model_clear();
        m_done  = 1'b0;
        m_csum  = 1'b0;
        m_fmt   = 1'b0;
        m_entry = 32'd0;
        m_rec   = 16'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard        = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready)
            checkOutput("in_ready_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0)
            @(negedge clk);
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        repeat (3) @(negedge clk);
        while (bus.mem_wren && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus.mem_wren)
            checkOutput("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic compare_writes(input string tag);
        wr_t g;
        wr_t e;
        checkOutput({tag, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        while (got_wr.size() > 0 && exp_wr.size() > 0) begin
            g = got_wr.pop_front();
            e = exp_wr.pop_front();
            checkOutput({tag, "_addr"}, g.addr, e.addr);
            checkOutput({tag, "_bena"}, g.bena, e.bena);
            checkOutput({tag, "_wdata"}, g.wdata, e.wdata);
        end
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic check_status(input string tag);
        checkOutput({tag, "_done"}, done, m_done);
        checkOutput({tag, "_entry"}, entry, m_entry);
        checkOutput({tag, "_err_csum"}, err_csum, m_csum);
        checkOutput({tag, "_err_fmt"}, err_fmt, m_fmt);
        checkOutput({tag, "_rec_cnt"}, rec_cnt, m_rec);
    endtask

    task automatic run_record(input string tag, input int t, input logic [31:0] addr,
                              input byte_q_t data, input bit bad);
        model_record(t, addr, data, bad);
        applyStimulus(make_record(t, addr, data, bad));
        if (t < 7 && $urandom_range(0, 1) == 1)
            applyStimulus("\r\n");
        drain();
        compare_writes(tag);
        check_status(tag);
    endtask

    function automatic logic [31:0] mask_addr(input int t, input logic [31:0] a);
        if (alen_of(t) == 2) return a & 32'h0000_FFFF;
        if (alen_of(t) == 3) return a & 32'h00FF_FFFF;
        return a;
    endfunction

    initial begin
        byte_q_t     dq;
        int          t;
        int          n;
        int          types[6];
        logic [31:0] a;
        bit          bad;

        types        = '{0, 1, 2, 3, 5, 6};
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_mem_wren", bus.mem_wren, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        checkOutput("rst_mem_bena", bus.mem_bena, 0);
        check_status("rst");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", bus.in_ready, 0);

        do_start();
        checkOutput("hunt_in_ready", bus.in_ready, 1);
        model_record(1, 32'h0, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
        applyStimulus("S1070000AABBCCDDEA\r\n");
        drain();
        compare_writes("s1_basic");
        check_status("s1_basic");

        model_record(3, 32'h1000_0002, '{8'h5A}, 1'b0);
        applyStimulus("S306100000025A8D");
        drain();
        compare_writes("s3_basic");
        check_status("s3_basic");

        model_record(1, 32'h0, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b1);
        applyStimulus("S1070000AABBCCDDEB\r\n");
        drain();
        compare_writes("s1_badsum");
        check_status("s1_badsum");

        model_record(9, 32'h0000_0100, '{}, 1'b0);
        applyStimulus("S9030100FB");
        drain();
        compare_writes("s9_term");
        check_status("s9_term");

        bus.in_data  = 8'h53;
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("after_done_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;

        do_start();
        check_status("start_clear");
        applyStimulus("S40300FC\r\n");
        m_fmt = 1'b1;
        check_status("fmt_type4");
        applyStimulus("S1G70000\r\n");
        check_status("fmt_nonhex");
        applyStimulus("S1020000FD\r\n");
        check_status("fmt_shortcnt");
        run_record("resync", 1, 32'h0000_0010, '{8'h11}, 1'b0);

        ack_delay = 10;
        stall_chk = 1'b1;
        run_record("stall", 1, 32'h0000_0003, '{8'h3C, 8'hC3}, 1'b0);
        stall_chk = 1'b0;
        ack_delay = 0;

        run_record("wrap", 3, 32'hFFFF_FFFE, '{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
        lower_hex = 1'b1;
        run_record("lower", 2, 32'h00AB_CDEF, '{8'hFE, 8'hED}, 1'b0);
        lower_hex = 1'b0;

        ack_delay = 20;
        applyStimulus("S10500203");
        send_byte(8'h33);
        checkOutput("abandon_pre_wren", bus.mem_wren, 1);
        do_start();
        checkOutput("abandon_wren", bus.mem_wren, 0);
        checkOutput("abandon_in_ready", bus.in_ready, 1);
        got_wr.delete();
        ack_delay = 0;

        gaps      = 1'b1;
        stray_ack = 1'b1;
        for (int r = 0; r < 25; r++) begin
            t = types[$urandom_range(0, 5)];
            a = mask_addr(t, $urandom);
            n = (r == 0) ? 0 : $urandom_range(0, 8);
            dq.delete();
            for (int i = 0; i < n; i++)
                dq.push_back(8'($urandom));
            bad       = ($urandom_range(0, 5) == 0);
            ack_delay = $urandom_range(0, 3);
            lower_hex = $urandom_range(0, 1) == 1;
            run_record($sformatf("rand%0d", r), t, a, dq, bad);
        end
        t = 7 + $urandom_range(0, 2);
        a = mask_addr(t, $urandom);
        dq.delete();
        run_record("rand_term", t, a, dq, 1'b0);
        gaps      = 1'b0;
        stray_ack = 1'b0;
        lower_hex = 1'b0;

        ack_delay = 30;
        do_start();
        applyStimulus("S1070000AA");
        checkOutput("rstmid_pre_wren", bus.mem_wren, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_in_ready", bus.in_ready, 0);
        checkOutput("rstmid_mem_wren", bus.mem_wren, 0);
        checkOutput("rstmid_mem_addr", bus.mem_addr, 0);
        checkOutput("rstmid_mem_wdata", bus.mem_wdata, 0);
        checkOutput("rstmid_mem_bena", bus.mem_bena, 0);
        model_clear();
        check_status("rstmid");
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        got_wr.delete();
        @(negedge clk);
        do_start();
        run_record("after_rst", 1, 32'h0000_0040, '{8'h12, 8'h34, 8'h56}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
